// File: rtl/rect_fill_pkg.sv
// Shared types and default screen geometry for the rectangle filler.
package rect_fill_pkg;

  typedef enum logic [1:0] {IDLE, CLIP, SCAN, DONE} state_t;
  typedef enum logic [1:0] {M_SOLID, M_CHECKER, M_GRADIENT, M_RSVD} mode_t;

  localparam int DEF_SCREEN_W = 160;
  localparam int DEF_SCREEN_H = 120;

endpackage

// File: rtl/rect_fill_pattern.sv
// Per-pixel colour generator; only the low coordinate bits affect the pattern.
module rect_fill_pattern
  import rect_fill_pkg::*;
#(
  parameter int CW = 3
) (
  input  mode_t         mode,
  input  logic [CW-1:0] colour,
  input  logic [CW-1:0] x_lsb,
  input  logic          y_lsb,
  output logic [CW-1:0] pix
);

  always_comb begin
    pix = colour;
    case (mode)
      M_CHECKER:  pix = (x_lsb[0] ^ y_lsb) ? ~colour : colour;
      M_GRADIENT: pix = colour + x_lsb;
      default:    pix = colour;
    endcase
  end

endmodule

// File: rtl/rect_fill.sv
// Clipped rectangle plotter: one pixel per clock, column-major, start/done handshake.
module rect_fill
  import rect_fill_pkg::*;
#(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int XW       = 8,
  parameter int YW       = 7,
  parameter int CW       = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [XW-1:0] x0,
  input  logic [XW-1:0] x1,
  input  logic [YW-1:0] y0,
  input  logic [YW-1:0] y1,
  input  logic [CW-1:0] colour,
  input  logic [1:0]    mode,
  output logic          busy,
  output logic          done,
  output logic [XW-1:0] vga_x,
  output logic [YW-1:0] vga_y,
  output logic [CW-1:0] vga_colour,
  output logic          vga_plot
);

  typedef struct packed {
    logic [XW-1:0] x0;
    logic [XW-1:0] x1;
    logic [YW-1:0] y0;
    logic [YW-1:0] y1;
    logic [CW-1:0] colour;
    mode_t         mode;
  } req_t;

  state_t        state;
  req_t          req;
  logic [XW-1:0] xh_r;
  logic [YW-1:0] yl_r, yh_r;

  logic [XW-1:0] xmin, xmax, xh_c, nx;
  logic [YW-1:0] ymin, ymax, yh_c, ny;
  logic          empty, col_end, last;
  logic [CW-1:0] pix;

  // Clip bounds; compares are one bit wider so a screen edge at 2**XW never wraps.
  always_comb begin
    xmin  = (req.x0 < req.x1) ? req.x0 : req.x1;
    xmax  = (req.x0 < req.x1) ? req.x1 : req.x0;
    ymin  = (req.y0 < req.y1) ? req.y0 : req.y1;
    ymax  = (req.y0 < req.y1) ? req.y1 : req.y0;
    xh_c  = ({1'b0, xmax} > (XW+1)'(SCREEN_W-1)) ? XW'(SCREEN_W-1) : xmax;
    yh_c  = ({1'b0, ymax} > (YW+1)'(SCREEN_H-1)) ? YW'(SCREEN_H-1) : ymax;
    empty = ({1'b0, xmin} >= (XW+1)'(SCREEN_W)) || ({1'b0, ymin} >= (YW+1)'(SCREEN_H));
  end

  assign col_end = (vga_y == yh_r);
  assign last    = col_end && (vga_x == xh_r);

  // Next pixel: the first corner while clipping, otherwise step y then x.
  always_comb begin
    nx = vga_x;
    ny = vga_y;
    if (state == CLIP) begin
      nx = xmin;
      ny = ymin;
    end else if (col_end) begin
      nx = vga_x + XW'(1);
      ny = yl_r;
    end else begin
      ny = vga_y + YW'(1);
    end
  end

  rect_fill_pattern #(.CW(CW)) u_pattern (
    .mode   (req.mode),
    .colour (req.colour),
    .x_lsb  (nx[CW-1:0]),
    .y_lsb  (ny[0]),
    .pix    (pix)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req        <= '0;
      xh_r       <= '0;
      yl_r       <= '0;
      yh_r       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done     <= 1'b0;
          vga_plot <= 1'b0;
          if (start) begin
            req   <= {x0, x1, y0, y1, colour, mode_t'(mode)};
            busy  <= 1'b1;
            state <= CLIP;
          end
        end
        CLIP: begin
          if (!start) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (empty) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            xh_r       <= xh_c;
            yl_r       <= ymin;
            yh_r       <= yh_c;
            vga_x      <= nx;
            vga_y      <= ny;
            vga_colour <= pix;
            vga_plot   <= 1'b1;
            state      <= SCAN;
          end
        end
        SCAN: begin
          if (!start) begin
            busy     <= 1'b0;
            vga_plot <= 1'b0;
            state    <= IDLE;
          end else if (last) begin
            busy     <= 1'b0;
            vga_plot <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            vga_x      <= nx;
            vga_y      <= ny;
            vga_colour <= pix;
          end
        end
        default: begin
          if (!start) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rect_fill.sv
// Scoreboarded bench for rect_fill: a reference model queues expected pixels, a monitor checks plots.
module tb_rect_fill;

  localparam int XW = 8;
  localparam int YW = 7;
  localparam int CW = 3;
  localparam int SW = 160;
  localparam int SH = 120;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [XW-1:0] x0 = '0, x1 = '0;
  logic [YW-1:0] y0 = '0, y1 = '0;
  logic [CW-1:0] colour = '0;
  logic [1:0]    mode = '0;
  logic          busy, done, vga_plot;
  logic [XW-1:0] vga_x;
  logic [YW-1:0] vga_y;
  logic [CW-1:0] vga_colour;

  typedef struct {int x; int y; int c;} pix_t;
  pix_t exp_q[$];

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  rect_fill #(.SCREEN_W(SW), .SCREEN_H(SH), .XW(XW), .YW(YW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .x0(x0), .x1(x1), .y0(y0), .y1(y1), .colour(colour), .mode(mode),
    .busy(busy), .done(done),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference colour rule straight from the pattern definitions.
  function automatic int ref_colour(input int m, input int c, input int x, input int y);
    int cmax = (1 << CW) - 1;
    case (m)
      1:       return (((x + y) % 2) == 1) ? (cmax - c) : c;
      2:       return (c + x) % (1 << CW);
      default: return c;
    endcase
  endfunction

  // Reference model: sort corners, reject off-screen, clip, enumerate column-major.
  task automatic build(input int ax0, ax1, ay0, ay1, c, m, output int p);
    int xl, xh, yl, yh;
    pix_t e;
    xl = (ax0 < ax1) ? ax0 : ax1;  xh = (ax0 < ax1) ? ax1 : ax0;
    yl = (ay0 < ay1) ? ay0 : ay1;  yh = (ay0 < ay1) ? ay1 : ay0;
    p = 0;
    if (xl >= SW || yl >= SH) return;
    if (xh > SW - 1) xh = SW - 1;
    if (yh > SH - 1) yh = SH - 1;
    for (int x = xl; x <= xh; x++)
      for (int y = yl; y <= yh; y++) begin
        e.x = x; e.y = y; e.c = ref_colour(m, c, x, y);
        exp_q.push_back(e);
        p++;
      end
  endtask

  always @(negedge clk) begin : monitor
    pix_t e;
    if (rst_n && vga_plot) begin
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_plot: got (%0d,%0d) c=%0d, expected no plot", vga_x, vga_y, vga_colour);
      end else begin
        e = exp_q.pop_front();
        if (int'(vga_x) != e.x || int'(vga_y) != e.y || int'(vga_colour) != e.c) begin
          errors++;
          $display("FAIL pixel: got (%0d,%0d) c=%0d expected (%0d,%0d) c=%0d",
                   vga_x, vga_y, vga_colour, e.x, e.y, e.c);
        end
      end
    end
  end

  task automatic drive(input int ax0, ax1, ay0, ay1, c, m);
    x0 = XW'(ax0); x1 = XW'(ax1); y0 = YW'(ay0); y1 = YW'(ay1);
    colour = CW'(c); mode = 2'(m);
    start = 1'b1;
  endtask

  task automatic run_op(input int ax0, ax1, ay0, ay1, c, m);
    int p, cnt;
    build(ax0, ax1, ay0, ay1, c, m, p);
    @(negedge clk);
    drive(ax0, ax1, ay0, ay1, c, m);
    cnt = 0;
    do begin
      @(posedge clk); cnt++;
      @(negedge clk);
      if (!done) chk("busy_during_op", busy, 1);
    end while (!done && cnt < p + 10);
    chk("done_latency", cnt, p + 2);
    chk("busy_at_done", busy, 0);
    chk("plot_at_done", vga_plot, 0);
    repeat (2) begin
      @(negedge clk);
      chk("done_held", done, 1);
    end
    start = 1'b0;
    @(negedge clk);
    chk("done_clear", done, 0);
    chk("pixels_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic run_abort(input int ax0, ax1, ay0, ay1, c, m, input int after);
    int p, cnt, plots;
    build(ax0, ax1, ay0, ay1, c, m, p);
    while (exp_q.size() > after) void'(exp_q.pop_back());
    @(negedge clk);
    drive(ax0, ax1, ay0, ay1, c, m);
    cnt = 0; plots = 0;
    while (plots < after && cnt < p + 10) begin
      @(posedge clk); cnt++;
      @(negedge clk);
      if (vga_plot) plots++;
    end
    chk("abort_plots_seen", plots, after);
    start = 1'b0;
    @(negedge clk);
    chk("abort_plot_low", vga_plot, 0);
    chk("abort_busy_low", busy, 0);
    repeat (3) begin
      chk("abort_no_done", done, 0);
      @(negedge clk);
    end
    chk("abort_pixels_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_x"}, vga_x, 0);
    chk({tag, "_y"}, vga_y, 0);
    chk({tag, "_colour"}, vga_colour, 0);
    chk({tag, "_plot"}, vga_plot, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int p, ax0, ax1, ay0, ay1;
    #2;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(0, 159, 0, 119, 3'b010, 0);     // full screen
    run_op(200, 150, 5, 3, 3'b001, 1);     // swapped + clipped checker
    run_op(170, 170, 10, 20, 3'b011, 0);   // fully off-screen
    run_op(0, 5, 127, 120, 3'b011, 0);     // off-screen in y only
    run_op(7, 7, 9, 9, 3'b101, 2);         // single pixel gradient
    run_op(159, 159, 0, 119, 3'b110, 1);   // single column on the right edge
    run_op(0, 255, 119, 119, 3'b100, 3);   // single row, reserved mode

    run_abort(0, 9, 0, 9, 3'b111, 0, 5);
    run_op(0, 9, 0, 9, 3'b111, 0);

    // Asynchronous reset mid-scan.
    build(0, 19, 0, 19, 3'b001, 2, p);
    @(negedge clk);
    drive(0, 19, 0, 19, 3'b001, 2);
    repeat (30) @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    exp_q.delete();
    start = 1'b0;
    #1 chk_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_done", done, 0);
    run_op(0, 19, 0, 19, 3'b001, 2);

    for (int i = 0; i < 20; i++) begin
      ax0 = int'($urandom_range(0, 175));
      ax1 = ax0 + int'($urandom_range(0, 30)) - 15;
      ay0 = int'($urandom_range(0, 130));
      ay1 = ay0 + int'($urandom_range(0, 30)) - 15;
      if (ax1 < 0) ax1 = 0;
      if (ax1 > 255) ax1 = 255;
      if (ay0 > 127) ay0 = 127;
      if (ay1 < 0) ay1 = 0;
      if (ay1 > 127) ay1 = 127;
      run_op(ax0, ax1, ay0, ay1, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
